// File: rtl/acc_cpu_controller.sv
// Multi-cycle control FSM for the accumulator CPU.
// Registered strobes: fetch handshake, flags, halt/resume, illegal-op pulse.
module acc_cpu_controller #(
  parameter int ARGW    = 4,
  parameter int ALUSELW = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [ARGW+3:0]    instr,
  input  logic               instr_valid,
  input  logic               alu_zero,
  input  logic               alu_carry,
  input  logic               resume,
  output logic               load_ir,
  output logic               inc_pc,
  output logic               load_pc,
  output logic               sel_pc,
  output logic               load_reg,
  output logic               dump_reg,
  output logic               load_acc,
  output logic [1:0]         sel_acc,
  output logic [ALUSELW-1:0] sel_alu,
  output logic [ARGW-1:0]    imm_data,
  output logic [ARGW-1:0]    reg_num,
  output logic               zero_flag,
  output logic               carry_flag,
  output logic               halted,
  output logic               illegal_op
);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_WB     = 3'd3;
  localparam logic [2:0] S_HALT   = 3'd4;

  localparam logic [ALUSELW-1:0] A_ADD = ALUSELW'(4'b0000);
  localparam logic [ALUSELW-1:0] A_SUB = ALUSELW'(4'b0001);
  localparam logic [ALUSELW-1:0] A_NOR = ALUSELW'(4'b1000);
  localparam logic [ALUSELW-1:0] A_SHR = ALUSELW'(4'b1100);
  localparam logic [ALUSELW-1:0] A_SHL = ALUSELW'(4'b1101);

  logic [2:0]         r_state;
  logic [3:0]         r_op;
  logic [ARGW-1:0]    r_arg;
  logic               r_load_ir;
  logic               r_inc_pc;
  logic               r_load_pc;
  logic               r_sel_pc;
  logic               r_load_reg;
  logic               r_dump_reg;
  logic               r_load_acc;
  logic [1:0]         r_sel_acc;
  logic [ALUSELW-1:0] r_sel_alu;
  logic [ARGW-1:0]    r_imm;
  logic [ARGW-1:0]    r_reg;
  logic               r_zf;
  logic               r_cf;
  logic               r_halted;
  logic               r_illegal;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_FETCH;
      r_op       <= '0;
      r_arg      <= '0;
      r_load_ir  <= 1'b0;
      r_inc_pc   <= 1'b0;
      r_load_pc  <= 1'b0;
      r_sel_pc   <= 1'b0;
      r_load_reg <= 1'b0;
      r_dump_reg <= 1'b0;
      r_load_acc <= 1'b0;
      r_sel_acc  <= 2'b00;
      r_sel_alu  <= '0;
      r_imm      <= '0;
      r_reg      <= '0;
      r_zf       <= 1'b0;
      r_cf       <= 1'b0;
      r_halted   <= 1'b0;
      r_illegal  <= 1'b0;
    end else begin
      // Strobes and selects default low; each state raises what it needs.
      r_load_ir  <= 1'b0;
      r_inc_pc   <= 1'b0;
      r_load_pc  <= 1'b0;
      r_sel_pc   <= 1'b0;
      r_load_reg <= 1'b0;
      r_dump_reg <= 1'b0;
      r_load_acc <= 1'b0;
      r_sel_acc  <= 2'b00;
      r_sel_alu  <= '0;
      r_illegal  <= 1'b0;
      unique case (r_state)
        S_FETCH: begin
          if (instr_valid) begin
            r_load_ir <= 1'b1;
            r_op      <= instr[ARGW+3 -: 4];
            r_arg     <= instr[ARGW-1:0];
            r_state   <= S_DECODE;
          end
        end
        S_DECODE: begin
          r_reg   <= r_arg;
          r_imm   <= r_arg;
          r_state <= S_EXEC;
        end
        S_EXEC: begin
          r_state <= S_FETCH;
          unique case (r_op)
            4'b0000: r_inc_pc <= 1'b1;
            4'b0001: begin
              r_dump_reg <= 1'b1;
              r_sel_alu  <= A_ADD;
              r_state    <= S_WB;
            end
            4'b0010: begin
              r_dump_reg <= 1'b1;
              r_sel_alu  <= A_SUB;
              r_state    <= S_WB;
            end
            4'b0011: begin
              r_dump_reg <= 1'b1;
              r_sel_alu  <= A_NOR;
              r_state    <= S_WB;
            end
            4'b1100: begin
              r_sel_alu <= A_SHR;
              r_state   <= S_WB;
            end
            4'b1011: begin
              r_sel_alu <= A_SHL;
              r_state   <= S_WB;
            end
            4'b0100: begin
              r_dump_reg <= 1'b1;
              r_load_acc <= 1'b1;
              r_sel_acc  <= 2'b01;
              r_inc_pc   <= 1'b1;
            end
            4'b0101: begin
              r_load_reg <= 1'b1;
              r_inc_pc   <= 1'b1;
            end
            4'b1101: begin
              r_load_acc <= 1'b1;
              r_inc_pc   <= 1'b1;
            end
            4'b0110, 4'b0111: begin
              if (r_zf) begin
                r_load_pc <= 1'b1;
                r_sel_pc  <= r_op[0];
              end else begin
                r_inc_pc  <= 1'b1;
              end
            end
            4'b1000, 4'b1010: begin
              if (r_cf) begin
                r_load_pc <= 1'b1;
                r_sel_pc  <= r_op[1];
              end else begin
                r_inc_pc  <= 1'b1;
              end
            end
            4'b1111: begin
              r_halted <= 1'b1;
              r_state  <= S_HALT;
            end
            default: begin
              r_illegal <= 1'b1;
              r_inc_pc  <= 1'b1;
            end
          endcase
        end
        S_WB: begin
          r_load_acc <= 1'b1;
          r_sel_acc  <= 2'b10;
          r_sel_alu  <= r_sel_alu;
          r_inc_pc   <= 1'b1;
          r_zf       <= alu_zero;
          r_cf       <= alu_carry;
          r_state    <= S_FETCH;
        end
        S_HALT: begin
          if (resume) begin
            r_inc_pc <= 1'b1;
            r_halted <= 1'b0;
            r_state  <= S_FETCH;
          end
        end
        default: r_state <= S_FETCH;
      endcase
    end
  end

  assign load_ir    = r_load_ir;
  assign inc_pc     = r_inc_pc;
  assign load_pc    = r_load_pc;
  assign sel_pc     = r_sel_pc;
  assign load_reg   = r_load_reg;
  assign dump_reg   = r_dump_reg;
  assign load_acc   = r_load_acc;
  assign sel_acc    = r_sel_acc;
  assign sel_alu    = r_sel_alu;
  assign imm_data   = r_imm;
  assign reg_num    = r_reg;
  assign zero_flag  = r_zf;
  assign carry_flag = r_cf;
  assign halted     = r_halted;
  assign illegal_op = r_illegal;

endmodule
